// File: rtl/nec_ir_pkg.sv
// rtl/nec_ir_pkg.sv - shared states, default timings and widths for the NEC IR transmitter
package nec_ir_pkg;

   localparam int NEC_BITS  = 32;
   localparam int NEC_CNT_W = 23;
   localparam int NEC_BIT_W = $clog2(NEC_BITS);

   localparam int unsigned DEF_LEAD_MARK    = 450_000;
   localparam int unsigned DEF_LEAD_SPACE   = 225_000;
   localparam int unsigned DEF_REP_SPACE    = 112_500;
   localparam int unsigned DEF_BIT_MARK     = 28_000;
   localparam int unsigned DEF_ZERO_SPACE   = 28_000;
   localparam int unsigned DEF_ONE_SPACE    = 84_500;
   localparam int unsigned DEF_FRAME_PERIOD = 5_500_000;
   localparam int unsigned DEF_CARRIER_HALF = 658;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEAD_MARK,
      ST_LEAD_SPACE,
      ST_BIT_MARK,
      ST_BIT_SPACE,
      ST_STOP_MARK,
      ST_GAP,
      ST_REP_MARK,
      ST_REP_SPACE
   } nec_state_e;

   function automatic logic is_mark(nec_state_e s);
      return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) ||
             (s == ST_STOP_MARK) || (s == ST_REP_MARK);
   endfunction

endpackage

// File: rtl/nec_ir_tx_carrier_gen.sv
// rtl/nec_ir_tx_carrier_gen.sv - registered 50 % carrier gated by the next-cycle envelope
module ir_carrier_gen
   import nec_ir_pkg::*;
#(
   parameter int unsigned HALF = DEF_CARRIER_HALF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic env_i,
   input  logic restart_i,
   output logic out_o
);

   logic [NEC_CNT_W-1:0] cnt_q, cnt_d;
   logic                 phase_q, phase_d;
   logic                 out_q, out_d;

   // env_i is the envelope for the coming cycle, so out_q lines up with the envelope register
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (restart_i) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (env_i) begin
         if (cnt_q == NEC_CNT_W'(HALF - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + NEC_CNT_W'(1);
         end
      end else begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end
      out_d = env_i & phase_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         out_q   <= out_d;
      end
   end

   assign out_o = out_q;

endmodule

// File: rtl/nec_ir_tx.sv
// rtl/nec_ir_tx.sv - NEC IR frame and repeat-code transmitter; define IR_CARRIER_EN for on-chip carrier
module nec_ir_tx
   import nec_ir_pkg::*;
#(
   parameter int unsigned LEAD_MARK    = DEF_LEAD_MARK,
   parameter int unsigned LEAD_SPACE   = DEF_LEAD_SPACE,
   parameter int unsigned REP_SPACE    = DEF_REP_SPACE,
   parameter int unsigned BIT_MARK     = DEF_BIT_MARK,
   parameter int unsigned ZERO_SPACE   = DEF_ZERO_SPACE,
   parameter int unsigned ONE_SPACE    = DEF_ONE_SPACE,
   parameter int unsigned FRAME_PERIOD = DEF_FRAME_PERIOD
`ifdef IR_CARRIER_EN
   ,
   parameter int unsigned CARRIER_HALF = DEF_CARRIER_HALF
`endif
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       tx_start,
   input  logic [7:0] tx_addr,
   input  logic [7:0] tx_cmd,
   input  logic       tx_repeat,
   output logic       busy,
   output logic       tx_done,
   output logic       ir_out
);

   nec_state_e           state_q, state_d;
   logic [NEC_BITS-1:0]  sr_q, sr_d;
   logic [NEC_BIT_W-1:0] bit_q, bit_d;
   logic [NEC_CNT_W-1:0] dcnt_q, dcnt_d;
   logic [NEC_CNT_W-1:0] pcnt_q, pcnt_d;
   logic [NEC_CNT_W-1:0] dur_last;
   logic                 tx_done_q, tx_done_d;
   logic                 env_d;

   always_comb begin
      dur_last = '0;
      case (state_q)
         ST_LEAD_MARK, ST_REP_MARK: dur_last = NEC_CNT_W'(LEAD_MARK - 1);
         ST_LEAD_SPACE:             dur_last = NEC_CNT_W'(LEAD_SPACE - 1);
         ST_BIT_MARK, ST_STOP_MARK: dur_last = NEC_CNT_W'(BIT_MARK - 1);
         ST_BIT_SPACE:              dur_last = sr_q[0] ? NEC_CNT_W'(ONE_SPACE - 1)
                                                       : NEC_CNT_W'(ZERO_SPACE - 1);
         ST_REP_SPACE:              dur_last = NEC_CNT_W'(REP_SPACE - 1);
         default:                   dur_last = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_d     = bit_q;
      tx_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // a request landing on the tx_done cycle is dropped
            if (tx_start && !tx_done_q) begin
               state_d = ST_LEAD_MARK;
               sr_d    = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
               bit_d   = '0;
            end
         end
         ST_LEAD_MARK:  if (dcnt_q == dur_last) state_d = ST_LEAD_SPACE;
         ST_LEAD_SPACE: if (dcnt_q == dur_last) state_d = ST_BIT_MARK;
         ST_BIT_MARK:   if (dcnt_q == dur_last) state_d = ST_BIT_SPACE;
         ST_BIT_SPACE: begin
            if (dcnt_q == dur_last) begin
               sr_d = sr_q >> 1;
               if (bit_q == NEC_BIT_W'(NEC_BITS - 1)) begin
                  state_d = ST_STOP_MARK;
               end else begin
                  bit_d   = bit_q + NEC_BIT_W'(1);
                  state_d = ST_BIT_MARK;
               end
            end
         end
         ST_STOP_MARK:  if (dcnt_q == dur_last) state_d = ST_GAP;
         ST_GAP: begin
            if (pcnt_q == NEC_CNT_W'(FRAME_PERIOD - 1)) begin
               if (tx_repeat) begin
                  state_d = ST_REP_MARK;
               end else begin
                  state_d   = ST_IDLE;
                  tx_done_d = 1'b1;
               end
            end
         end
         ST_REP_MARK:   if (dcnt_q == dur_last) state_d = ST_REP_SPACE;
         ST_REP_SPACE:  if (dcnt_q == dur_last) state_d = ST_STOP_MARK;
         default:       state_d = ST_IDLE;
      endcase

      dcnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : dcnt_q + NEC_CNT_W'(1);

      // period is measured leader-start to leader-start
      if (((state_d == ST_LEAD_MARK) || (state_d == ST_REP_MARK)) && (state_d != state_q))
         pcnt_d = '0;
      else if (state_q == ST_IDLE)
         pcnt_d = '0;
      else
         pcnt_d = pcnt_q + NEC_CNT_W'(1);

      env_d = is_mark(state_d);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         bit_q     <= '0;
         dcnt_q    <= '0;
         pcnt_q    <= '0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_q     <= bit_d;
         dcnt_q    <= dcnt_d;
         pcnt_q    <= pcnt_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign tx_done = tx_done_q;

`ifdef IR_CARRIER_EN
   logic mark_entry;
   assign mark_entry = env_d && (state_d != state_q);

   ir_carrier_gen #(
      .HALF (CARRIER_HALF)
   ) u_carrier (
      .clk_i     (sys_clk),
      .rst_i     (sys_rst),
      .env_i     (env_d),
      .restart_i (mark_entry),
      .out_o     (ir_out)
   );
`else
   logic ir_out_q;
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) ir_out_q <= 1'b0;
      else         ir_out_q <= env_d;
   end
   assign ir_out = ir_out_q;
`endif

endmodule

// File: tb/tb_nec_ir_tx.sv
// tb/tb_nec_ir_tx.sv - self-checking bench for nec_ir_tx against a segment-level waveform model
module tb_nec_ir_tx;

   localparam int LM = 90;
   localparam int LS = 45;
   localparam int RS = 22;
   localparam int BM = 6;
   localparam int ZS = 6;
   localparam int OS = 17;
   localparam int FP = 2000;
`ifdef IR_CARRIER_EN
   localparam int CH     = 2;
   localparam int GLITCH = CH;
`else
   localparam int GLITCH = 0;
`endif

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_addr = 8'h00;
   logic [7:0] tx_cmd = 8'h00;
   logic       tx_repeat = 1'b0;
   logic       busy;
   logic       tx_done;
   logic       ir_out;

   int n_checks = 0;
   int n_errors = 0;

   bit exp_q[$];
   bit cap_q[$];
   int run_lvl[$];
   int run_len[$];

   nec_ir_tx #(
      .LEAD_MARK    (LM),
      .LEAD_SPACE   (LS),
      .REP_SPACE    (RS),
      .BIT_MARK     (BM),
      .ZERO_SPACE   (ZS),
      .ONE_SPACE    (OS),
      .FRAME_PERIOD (FP)
`ifdef IR_CARRIER_EN
      ,
      .CARRIER_HALF (CH)
`endif
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .tx_start  (tx_start),
      .tx_addr   (tx_addr),
      .tx_cmd    (tx_cmd),
      .tx_repeat (tx_repeat),
      .busy      (busy),
      .tx_done   (tx_done),
      .ir_out    (ir_out)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic bit carrier_at(int i);
`ifdef IR_CARRIER_EN
      return ((i / CH) % 2) == 0;
`else
      return i >= 0;
`endif
   endfunction

   task automatic push_seg(input bit lvl, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(lvl && carrier_at(i));
   endtask

   task automatic build_frame(input logic [7:0] a, input logic [7:0] c);
      logic [31:0] word;
      word = {~c, c, ~a, a};
      exp_q.delete();
      push_seg(1'b1, LM);
      push_seg(1'b0, LS);
      for (int i = 0; i < 32; i++) begin
         push_seg(1'b1, BM);
         push_seg(1'b0, word[i] ? OS : ZS);
      end
      push_seg(1'b1, BM);
      push_seg(1'b0, FP - exp_q.size());
   endtask

   task automatic build_repeat();
      exp_q.delete();
      push_seg(1'b1, LM);
      push_seg(1'b0, RS);
      push_seg(1'b1, BM);
      push_seg(1'b0, FP - exp_q.size());
   endtask

   task automatic send_start(input logic [7:0] a, input logic [7:0] c);
      @(negedge sys_clk);
      tx_addr  = a;
      tx_cmd   = c;
      tx_start = 1'b1;
      @(negedge sys_clk);
      tx_start = 1'b0;
   endtask

   // Samples one full period starting at the first leader cycle; leaves us on the cycle after it.
   task automatic capture_period(input string name, input bit final_rep, input int inject_at, input bit noise);
      int bad_ir, bad_ctl, first;
      bit got_first, want_first;
      bad_ir = 0; bad_ctl = 0; first = -1; got_first = 0; want_first = 0;
      cap_q.delete();
      for (int k = 0; k < FP; k++) begin
         cap_q.push_back(ir_out);
         if (ir_out !== exp_q[k]) begin
            if (first < 0) begin
               first = k; got_first = ir_out; want_first = exp_q[k];
            end
            bad_ir++;
         end
         if (busy !== 1'b1 || tx_done !== 1'b0) bad_ctl++;
         if (k == inject_at) begin
            tx_start = 1'b1; tx_addr = 8'h12; tx_cmd = 8'hEE;
         end else begin
            tx_start = 1'b0;
         end
         tx_repeat = (noise && k < FP - 10) ? 1'($urandom_range(0, 1)) : final_rep;
         @(negedge sys_clk);
      end
      n_checks++;
      if (bad_ir != 0) begin
         n_errors++;
         $display("FAIL %s waveform: %0d cycles differ, first at cycle %0d got %b want %b",
                  name, bad_ir, first, got_first, want_first);
      end
      n_checks++;
      if (bad_ctl != 0) begin
         n_errors++;
         $display("FAIL %s busy_during: %0d cycles with busy!=1 or tx_done!=0, want 0", name, bad_ctl);
      end
   endtask

   task automatic check_done(input string name);
      n_checks++;
      if (tx_done !== 1'b1 || busy !== 1'b0 || ir_out !== 1'b0) begin
         n_errors++;
         $display("FAIL %s done_pulse: tx_done=%b busy=%b ir_out=%b want 1 0 0", name, tx_done, busy, ir_out);
      end
      @(negedge sys_clk);
      n_checks++;
      if (tx_done !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL %s done_width: tx_done=%b busy=%b want 0 0", name, tx_done, busy);
      end
   endtask

   // Rebuilds the envelope from the captured pin, absorbing carrier low half-cycles inside marks.
   task automatic envelope_runs();
      int lv[$];
      int ln[$];
      run_lvl.delete();
      run_len.delete();
      foreach (cap_q[i]) begin
         if (lv.size() == 0 || lv[lv.size()-1] != int'(cap_q[i])) begin
            lv.push_back(int'(cap_q[i]));
            ln.push_back(1);
         end else begin
            ln[ln.size()-1] = ln[ln.size()-1] + 1;
         end
      end
      for (int r = 0; r < lv.size(); r++) begin
         int l;
         l = lv[r];
         if (l == 0 && ln[r] <= GLITCH && r > 0 && r < lv.size() - 1) l = 1;
         if (run_lvl.size() > 0 && run_lvl[run_lvl.size()-1] == l) begin
            run_len[run_len.size()-1] = run_len[run_len.size()-1] + ln[r];
         end else begin
            run_lvl.push_back(l);
            run_len.push_back(ln[r]);
         end
      end
   endtask

   task automatic decode_frame(input string name, input logic [31:0] exp_word);
      logic [31:0] word;
      int bad_marks;
      word = '0;
      bad_marks = 0;
      envelope_runs();
      n_checks++;
      if (run_len.size() != 68) begin
         n_errors++;
         $display("FAIL %s run_count: got %0d want 68", name, run_len.size());
      end else begin
         n_checks++;
         if (run_lvl[0] != 1 || run_len[0] != LM || run_len[1] != LS) begin
            n_errors++;
            $display("FAIL %s leader: got %0d/%0d want %0d/%0d", name, run_len[0], run_len[1], LM, LS);
         end
         for (int i = 0; i < 32; i++) begin
            if (run_len[2+2*i] != BM) bad_marks++;
            word[i] = run_len[3+2*i] > (ZS + OS) / 2;
         end
         n_checks++;
         if (word !== exp_word) begin
            n_errors++;
            $display("FAIL %s bits: got %h want %h", name, word, exp_word);
         end
         n_checks++;
         if (bad_marks != 0) begin
            n_errors++;
            $display("FAIL %s bit_marks: %0d marks not %0d wide, want 0", name, bad_marks, BM);
         end
         n_checks++;
         if (run_len[66] != BM) begin
            n_errors++;
            $display("FAIL %s stop_mark: got %0d want %0d", name, run_len[66], BM);
         end
      end
   endtask

   task automatic decode_repeat(input string name);
      envelope_runs();
      n_checks++;
      if (run_len.size() != 4 || run_lvl[0] != 1 || run_len[0] != LM ||
          run_len[1] != RS || run_len[2] != BM) begin
         n_errors++;
         $display("FAIL %s repeat_shape: runs=%0d first=%0d want 4 runs %0d/%0d/%0d",
                  name, run_len.size(), run_len[0], LM, RS, BM);
      end
   endtask

   task automatic test_reset();
      int bad;
      bad = 0;
      repeat (2) @(negedge sys_clk);
      n_checks++;
      if (ir_out !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state: ir_out=%b busy=%b tx_done=%b want 0 0 0", ir_out, busy, tx_done);
      end
      sys_rst = 1'b0;
      repeat (5) begin
         @(negedge sys_clk);
         if (ir_out !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL reset_idle: %0d active cycles, want 0", bad);
      end
   endtask

   task automatic test_single_frame();
      send_start(8'h00, 8'h45);
      build_frame(8'h00, 8'h45);
      capture_period("single", 1'b0, -1, 1'b0);
      check_done("single");
      decode_frame("single", 32'hBA45_FF00);
   endtask

   task automatic test_repeat();
      logic [7:0] a, c;
      a = 8'($urandom);
      c = 8'($urandom);
      send_start(a, c);
      build_frame(a, c);
      capture_period("rep_frame", 1'b1, -1, 1'b1);
      decode_frame("rep_frame", {~c, c, ~a, a});
      for (int r = 0; r < 3; r++) begin
         build_repeat();
         capture_period($sformatf("repeat%0d", r), r < 2, -1, 1'b0);
         decode_repeat($sformatf("repeat%0d", r));
      end
      check_done("repeat");
   endtask

   task automatic test_busy_reject();
      int bad;
      bad = 0;
      send_start(8'h00, 8'h45);
      build_frame(8'h00, 8'h45);
      capture_period("busy_rej", 1'b0, 300, 1'b0);
      check_done("busy_rej");
      decode_frame("busy_rej", 32'hBA45_FF00);
      repeat (200) begin
         @(negedge sys_clk);
         if (busy !== 1'b0 || ir_out !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL busy_rej no_second_frame: %0d active cycles, want 0", bad);
      end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      logic [7:0] a, c;
      bad = 0;
      send_start(8'h00, 8'h45);
      repeat (280) @(negedge sys_clk);
      #2 sys_rst = 1'b1;
      #1;
      n_checks++;
      if (ir_out !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mid immediate: ir_out=%b busy=%b want 0 0", ir_out, busy);
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (FP + 50) begin
         @(negedge sys_clk);
         if (tx_done !== 1'b0 || busy !== 1'b0 || ir_out !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL rst_mid quiet_after: %0d active cycles, want 0", bad);
      end
      a = 8'($urandom);
      c = 8'($urandom);
      send_start(a, c);
      build_frame(a, c);
      capture_period("rst_clean", 1'b0, -1, 1'b0);
      check_done("rst_clean");
      decode_frame("rst_clean", {~c, c, ~a, a});
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, c;
      a = 8'($urandom);
      c = 8'($urandom);
      send_start(a, c);
      build_frame(a, c);
      capture_period("b2b_first", 1'b0, -1, 1'b0);
      n_checks++;
      if (tx_done !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b done_pulse: tx_done=%b busy=%b want 1 0", tx_done, busy);
      end
      a = 8'($urandom);
      c = 8'($urandom);
      tx_addr  = a;
      tx_cmd   = c;
      tx_start = 1'b1;
      @(negedge sys_clk);
      n_checks++;
      if (busy !== 1'b0 || ir_out !== 1'b0 || tx_done !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b coincident_ignored: busy=%b ir_out=%b tx_done=%b want 0 0 0", busy, ir_out, tx_done);
      end
      @(negedge sys_clk);
      tx_start = 1'b0;
      build_frame(a, c);
      capture_period("b2b_second", 1'b0, -1, 1'b0);
      check_done("b2b_second");
      decode_frame("b2b_second", {~c, c, ~a, a});
   endtask

   task automatic test_random_frames();
      logic [7:0] a, c;
      for (int n = 0; n < 2; n++) begin
         a = 8'($urandom);
         c = 8'($urandom);
         send_start(a, c);
         build_frame(a, c);
         capture_period($sformatf("rand%0d", n), 1'b0, -1, 1'b1);
         check_done($sformatf("rand%0d", n));
         decode_frame($sformatf("rand%0d", n), {~c, c, ~a, a});
      end
   endtask

`ifdef IR_CARRIER_EN
   task automatic test_carrier();
      logic [7:0] a, c;
      logic [7:0] head;
      int bad_space;
      a = 8'($urandom);
      c = 8'($urandom);
      bad_space = 0;
      send_start(a, c);
      build_frame(a, c);
      capture_period("carrier", 1'b0, -1, 1'b0);
      check_done("carrier");
      for (int i = 0; i < 8; i++) head[7-i] = cap_q[i];
      n_checks++;
      if (head !== 8'b1100_1100) begin
         n_errors++;
         $display("FAIL carrier head: got %b want 11001100", head);
      end
      for (int i = LM; i < LM + LS; i++) if (cap_q[i] != 1'b0) bad_space++;
      n_checks++;
      if (bad_space != 0) begin
         n_errors++;
         $display("FAIL carrier space_low: %0d high cycles, want 0", bad_space);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_repeat();
      test_busy_reject();
      test_reset_mid_frame();
      test_back_to_back();
      test_random_frames();
`ifdef IR_CARRIER_EN
      test_carrier();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nec_ir_tx.md
# nec_ir_tx

NEC-protocol infrared transmitter, the sending counterpart to the board's IR receive path. It accepts an 8-bit address and an 8-bit command on a start pulse and serialises a full NEC frame onto `ir_out`. While `tx_repeat` is held, it follows the frame with NEC repeat codes at the standard 110 ms period. It sits between the key-scan/control logic and the IR LED driver pin.

## Interface
- `LEAD_MARK`, default 450_000: leader burst length in clocks (9 ms at 50 MHz).
- `LEAD_SPACE`, default 225_000: leader space (4.5 ms).
- `REP_SPACE`, default 112_500: repeat-code space (2.25 ms).
- `BIT_MARK`, default 28_000: bit/stop burst (560 µs).
- `ZERO_SPACE`, default 28_000: logic-0 space (560 µs).
- `ONE_SPACE`, default 84_500: logic-1 space (1.69 ms).
- `FRAME_PERIOD`, default 5_500_000: frame/repeat period measured from leader start (110 ms).
- `CARRIER_HALF`, default 658: carrier half-period (≈38 kHz).
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `tx_start`  in  1  one-cycle request; honoured only when `busy`=0.
- `tx_addr`  in  8  address; latched on an accepted `tx_start`.
- `tx_cmd`  in  8  command; latched on an accepted `tx_start`.
- `tx_repeat`  in  1  level; sampled at the end of each period to decide whether a repeat code follows.
- `busy`  out  1  high from the cycle after acceptance until the return to IDLE.
- `tx_done`  out  1  one-cycle pulse on the return to IDLE.
- `ir_out`  out  1  registered IR drive; high means emit.

## Operation
- The shift register is loaded with `{~tx_cmd, tx_cmd, ~tx_addr, tx_addr}` (32 bits) and sent LSB first, so address bit 0 goes out first.
- FSM states and transitions:
  - IDLE → LEAD_MARK → LEAD_SPACE → BIT_MARK ↔ BIT_SPACE (×32) → STOP_MARK → GAP.
  - GAP → REP_MARK → REP_SPACE → STOP_MARK (repeat) → GAP, or GAP → IDLE.
- Durations: LEAD_MARK = `LEAD_MARK`; LEAD_SPACE = `LEAD_SPACE`; each BIT_MARK and STOP_MARK = `BIT_MARK`; BIT_SPACE = `ZERO_SPACE` or `ONE_SPACE` per the current bit; REP_MARK = `LEAD_MARK`; REP_SPACE = `REP_SPACE`.
- Mark states drive envelope = 1; all other states drive envelope = 0.
- A 23-bit period counter clears on entry to LEAD_MARK or REP_MARK and free-runs. GAP exits when it reaches `FRAME_PERIOD-1`.
- At GAP exit:
  - `tx_repeat`=1 → REP_MARK.
  - otherwise → IDLE with `tx_done`.
- Reset values: `ir_out`=0, `busy`=0, `tx_done`=0, state IDLE, all counters 0.
- Boundary rules:
  - `tx_start` while `busy` is ignored; latched data is not disturbed.
  - `tx_start` coincident with `tx_done` is ignored; it is accepted from the following cycle.
  - `tx_repeat` changes mid-frame have no effect until GAP exit.
  - Reset asserted mid-frame forces `ir_out`=0 immediately and abandons the frame; no `tx_done` is issued.
  - Parameter values of 0 are illegal.

## Timing
- Accepted `tx_start` at cycle N: `busy`=1 and `ir_out` envelope=1 from N+1.
- Every state lasts exactly its parameter count of cycles; the duration counter is compared against `param-1`.
- Full frame = 67.5 ms of symbols followed by idle low until 110 ms. `tx_done` pulses at cycle N+1+`FRAME_PERIOD` when no repeat follows.
- The spacing between repeat codes, and between a frame and its first repeat, is exactly `FRAME_PERIOD` cycles leader-start to leader-start.
- `busy` falls in the same cycle that `tx_done` pulses.

## Configuration
- `IR_CARRIER_EN` defined:
  - `ir_out` = envelope AND a 50 %-duty carrier toggling every `CARRIER_HALF` cycles.
  - The carrier counter restarts at each mark entry so every burst begins with a high half-cycle.
  - The carrier output is registered and adds no cycle of latency relative to the envelope.
- `IR_CARRIER_EN` undefined: `ir_out` = envelope, for an external modulator; no carrier logic is synthesised.

## Structure
- Package `nec_ir_pkg`:
  - FSM state enum.
  - Default timing constants listed above.
  - `NEC_BITS`=32.
  - Counter width `NEC_CNT_W`=23.
- Sub-module `ir_carrier_gen` (counter plus toggle, enable = envelope), instantiated only under `IR_CARRIER_EN`.

## Test plan
All scenarios use scaled parameters: `LEAD_MARK`=90, `LEAD_SPACE`=45, `REP_SPACE`=22, `BIT_MARK`=6, `ZERO_SPACE`=6, `ONE_SPACE`=17, `FRAME_PERIOD`=2000.
- **Single frame.** `tx_addr`=0x00, `tx_cmd`=0x45, one `tx_start`.
  - Decoded mark/space widths give bit stream 0x00, 0xFF, 0x45, 0xBA, LSB first.
  - Stop mark is 6 cycles wide.
  - `tx_done` fires 2000 cycles after the leader rises.
- **Repeat.** Hold `tx_repeat`=1 for 3 periods after the frame.
  - Three 90/22/6 repeat codes, each starting 2000 cycles apart.
  - Drop `tx_repeat` → `tx_done` at the end of the next GAP.
- **Busy rejection.** Pulse `tx_start` with addr 0x12 mid-frame.
  - Transmitted address is still 0x00.
  - No second frame is sent.
- **Reset mid-frame.** Assert `sys_rst` during bit 10.
  - `ir_out`=0 and `busy`=0 in the same cycle.
  - No `tx_done`.
  - A new `tx_start` after release produces a clean frame.
- **Carrier.** With `IR_CARRIER_EN` and `CARRIER_HALF`=2:
  - Marks show a 4-cycle-period toggle, starting high.
  - Spaces stay 0.
- **Back-to-back.** `tx_start` on the cycle after `tx_done`.
  - Accepted; the next leader rises one cycle later.
